// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU constants: datapath width, register-file defaults
//               and opcode encodings used by the ALU and its issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DW   = 32;
    localparam int ALU_NREG = 8;
    localparam int ALU_AW   = 3;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADC  = 4'd1,
        OP_SUB  = 4'd2,
        OP_SBC  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOT  = 4'd7,
        OP_MOV  = 4'd8,
        OP_SLL  = 4'd9,
        OP_SRL  = 4'd10,
        OP_SRA  = 4'd11
    } alu_op_e;

    // Opcodes above OP_SRA are pass-through and never return a result.
    function automatic logic op_writes_back(input logic [3:0] op);
        return op <= OP_SRA;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile_2r1w
// Description : NREG x DW register file, two combinational read ports with
//               write-through bypass, one write port, synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile_2r1w
    import alu_pkg::*;
#(
    parameter int NREG = ALU_NREG,
    parameter int DW   = ALU_DW,
    parameter int AW   = ALU_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we && (int'(waddr) < NREG)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // A same-cycle write to the addressed register is forwarded to the reader.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else if (int'(raddr_a) < NREG) begin
            rdata_a = mem_q[raddr_a];
        end
        if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else if (int'(raddr_b) < NREG) begin
            rdata_b = mem_q[raddr_b];
        end
    end

endmodule : alu_regfile_2r1w
`default_nettype wire

// File: rtl/alu_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_fetch
// Description : ALU issue stage: operand read, RAW scoreboard, valid/ready
//               handshake and 1-entry output register; absorbs writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_fetch
    import alu_pkg::*;
#(
    parameter int DW   = ALU_DW,
    parameter int NREG = ALU_NREG,
    parameter int AW   = ALU_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs,
    input  logic          in_use_imm,
    input  logic [DW-1:0] in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_op,
    output logic [DW-1:0] out_tr,
    output logic [DW-1:0] out_sr,
    output logic [AW-1:0] out_rd,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    input  logic          wb_cf,
    output logic          cf_q
);

    logic [NREG-1:0] pend_q, pend_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      out_op_q, out_op_d;
    logic [DW-1:0]   out_tr_q, out_tr_d;
    logic [DW-1:0]   out_sr_q, out_sr_d;
    logic [AW-1:0]   out_rd_q, out_rd_d;
    logic            cf_d;

    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_pend_eff;
    logic            w_hazard;
    logic            w_accept;
    logic [DW-1:0]   w_rd_data;
    logic [DW-1:0]   w_rs_data;

    alu_regfile_2r1w #(
        .NREG (NREG),
        .DW   (DW),
        .AW   (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (in_rd),
        .rdata_a (w_rd_data),
        .raddr_b (in_rs),
        .rdata_b (w_rs_data)
    );

    for (genvar i = 0; i < NREG; i++) begin : g_pend
        assign w_clr[i] = wb_en    && (wb_rd == AW'(i));
        assign w_set[i] = w_accept && (in_rd == AW'(i));
    end

    // A register being written back this cycle no longer blocks its readers.
    assign w_pend_eff = pend_q & ~w_clr;
    assign w_hazard   = w_pend_eff[in_rd] | (!in_use_imm & w_pend_eff[in_rs]);
    assign in_ready   = (!out_valid_q | out_ready) & !w_hazard;
    assign w_accept   = in_valid & in_ready;

    always_comb begin
        pend_d      = w_pend_eff | w_set;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_tr_d    = out_tr_q;
        out_sr_d    = out_sr_q;
        out_rd_d    = out_rd_q;
        cf_d        = wb_en ? wb_cf : cf_q;
        if (w_accept) begin
            out_valid_d = 1'b1;
            out_op_d    = in_op;
            out_tr_d    = w_rd_data;
            out_sr_d    = in_use_imm ? in_imm : w_rs_data;
            out_rd_d    = in_rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_tr_q    <= '0;
            out_sr_q    <= '0;
            out_rd_q    <= '0;
            cf_q        <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_tr_q    <= out_tr_d;
            out_sr_q    <= out_sr_d;
            out_rd_q    <= out_rd_d;
            cf_q        <= cf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_tr    = out_tr_q;
    assign out_sr    = out_sr_q;
    assign out_rd    = out_rd_q;

endmodule : alu_operand_fetch
`default_nettype wire

// File: tb/tb_alu_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_fetch
// Description : Scoreboard bench for alu_operand_fetch with a register-array
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_fetch;

    localparam int DW   = 32;
    localparam int NREG = 8;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [AW-1:0] in_rd = '0;
    logic [AW-1:0] in_rs = '0;
    logic          in_use_imm = 1'b0;
    logic [DW-1:0] in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_op;
    logic [DW-1:0] out_tr;
    logic [DW-1:0] out_sr;
    logic [AW-1:0] out_rd;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          wb_cf = 1'b0;
    logic          cf_q;

    alu_operand_fetch #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_tr     (out_tr),
        .out_sr     (out_sr),
        .out_rd     (out_rd),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_cf      (wb_cf),
        .cf_q       (cf_q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    op;
        logic [DW-1:0] tr;
        logic [DW-1:0] sr;
        logic [AW-1:0] rd;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] inflight[$];

    // Reference architectural state
    logic [DW-1:0] m_reg [NREG];
    bit            m_pend [NREG];
    bit            m_cf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_cf = 1'b0;
        exp_q.delete();
        inflight.delete();
    endtask

    // Evaluated mid-cycle, after inputs settle and before the next rising edge.
    task automatic model_step();
        bit            blk_rd, blk_rs, exp_ready;
        exp_t          e;
        if (rst) begin
            model_reset();
            return;
        end
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("cf_q", 64'(cf_q), 64'(m_cf));
        blk_rd    = m_pend[in_rd] && !(wb_en && wb_rd == in_rd);
        blk_rs    = !in_use_imm && m_pend[in_rs] && !(wb_en && wb_rd == in_rs);
        exp_ready = (exp_q.size() == 0 || out_ready) && !blk_rd && !blk_rs;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        if (in_valid && exp_ready) begin
            e.op = in_op;
            e.rd = in_rd;
            e.tr = (wb_en && wb_rd == in_rd) ? wb_data : m_reg[in_rd];
            if (in_use_imm)
                e.sr = in_imm;
            else
                e.sr = (wb_en && wb_rd == in_rs) ? wb_data : m_reg[in_rs];
            exp_q.push_back(e);
        end
        if (wb_en) begin
            m_reg[wb_rd]  = wb_data;
            m_pend[wb_rd] = 1'b0;
            m_cf          = wb_cf;
        end
        if (in_valid && exp_ready) m_pend[in_rd] = 1'b1;
    endtask

    task automatic cycle(input bit r, input bit v, input logic [3:0] op,
                         input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input bit ui, input logic [DW-1:0] imm, input bit ordy,
                         input bit we, input logic [AW-1:0] wr,
                         input logic [DW-1:0] wd, input bit wc);
        @(posedge clk);
        #1;
        rst        = r;
        in_valid   = v;
        in_op      = op;
        in_rd      = rd;
        in_rs      = rs;
        in_use_imm = ui;
        in_imm     = imm;
        out_ready  = ordy;
        wb_en      = we;
        wb_rd      = wr;
        wb_data    = wd;
        wb_cf      = wc;
        #3;
        model_step();
    endtask

    task automatic idle(input bit r, input bit ordy);
        cycle(r, 0, 4'd0, '0, '0, 0, '0, ordy, 0, '0, '0, 0);
    endtask

    // Monitor: the head of the queue is whatever the output register must show.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("out_op", 64'(out_op), 64'(exp_q[0].op));
                chk("out_tr", 64'(out_tr), 64'(exp_q[0].tr));
                chk("out_sr", 64'(out_sr), 64'(exp_q[0].sr));
                chk("out_rd", 64'(out_rd), 64'(exp_q[0].rd));
                if (out_ready) begin
                    if (exp_q[0].op < 4'd12) inflight.push_back(exp_q[0].rd);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit            r, v, ui, ordy, we, wc;
        logic [3:0]    op;
        logic [AW-1:0] rd, rs, wr;
        logic [DW-1:0] imm, wd;

        model_reset();
        idle(1, 0);
        idle(1, 0);
        // Reset then idle
        idle(0, 1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_op", 64'(out_op), 64'd0);
        chk("rst_out_tr", 64'(out_tr), 64'd0);
        chk("rst_out_sr", 64'(out_sr), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_cf_q", 64'(cf_q), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Immediate issue: ADD r1, #5
        cycle(0, 1, 4'd0, 3'd1, 3'd0, 1, 32'd5, 1, 0, '0, '0, 0);
        // RAW stall on r1, released by its writeback with bypass
        cycle(0, 1, 4'd0, 3'd2, 3'd1, 0, '0, 1, 0, '0, '0, 0);
        chk("raw_stall_in_ready", 64'(in_ready), 64'd0);
        cycle(0, 1, 4'd0, 3'd2, 3'd1, 0, '0, 1, 0, '0, '0, 0);
        cycle(0, 1, 4'd0, 3'd2, 3'd1, 0, '0, 1, 1, 3'd1, 32'd5, 0);
        chk("raw_release_in_ready", 64'(in_ready), 64'd1);
        // Backpressure: output held for 3 cycles, then released
        for (int i = 0; i < 3; i++)
            cycle(0, 1, 4'd1, 3'd5, 3'd0, 1, 32'd7, 0, 0, '0, '0, 0);
        cycle(0, 1, 4'd1, 3'd5, 3'd0, 1, 32'd7, 1, 0, '0, '0, 0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        // Same-cycle set/clear of r3 plus carry
        cycle(0, 1, 4'd2, 3'd3, 3'd0, 1, 32'd9, 1, 1, 3'd3, 32'hABCD, 1);
        cycle(0, 1, 4'd2, 3'd3, 3'd0, 1, 32'd9, 1, 0, '0, '0, 0);
        chk("collision_pend_held", 64'(in_ready), 64'd0);
        chk("collision_cf", 64'(cf_q), 64'd1);
        // Reset with output held and r4 pending
        idle(0, 1);
        cycle(0, 1, 4'd0, 3'd4, 3'd0, 1, 32'h44, 0, 1, 3'd4, 32'h1234, 1);
        idle(0, 0);
        idle(1, 0);
        idle(0, 0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_cf", 64'(cf_q), 64'd0);
        cycle(0, 1, 4'd0, 3'd4, 3'd4, 0, '0, 1, 0, '0, '0, 0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);

        // Random traffic; the bench acts as the ALU returning results
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom % 300) == 0;
            v    = ($urandom % 4) != 0;
            op   = 4'($urandom);
            rd   = AW'($urandom);
            rs   = AW'($urandom);
            ui   = 1'($urandom);
            imm  = $urandom;
            ordy = ($urandom % 4) != 0;
            we   = 0;
            wr   = '0;
            if (inflight.size() > 0 && ($urandom % 3) != 0) begin
                we = 1;
                wr = inflight.pop_front();
            end else if (($urandom % 8) == 0) begin
                we = 1;
                wr = AW'($urandom);
            end
            wd   = $urandom;
            wc   = 1'($urandom);
            cycle(r, v, op, rd, rs, ui, imm, ordy, we, wr, wd, wc);
        end

        for (int n = 0; n < 10; n++) idle(0, 1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_operand_fetch
`default_nettype wire
